binned_centroid: RTL and testbench

Consumes the 320x180 binary pixel stream produced by the 4x4 binning stage and computes per-frame statistics of the set pixels: pixel count, bounding box, and integer centroid. It sits directly downstream of binning and feeds the tracking/overlay logic. Accumulation runs at stream rate. At each frame end the totals are snapshotted and divided by two sequential dividers, so accumulation of the next frame overlaps the division.

---
 rtl/binned_pkg.sv | 28 ++
 rtl/seq_divider.sv | 63 ++++++
 rtl/binned_centroid.sv | 183 ++++++++++++++++++
 tb/tb_binned_centroid.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/binned_pkg.sv
// Shared definitions for the binned-frame centroid block: frame geometry,
// coordinate widths, result-path FSM states and the published result record.
package binned_pkg;

  localparam int H_BINS = 320;
  localparam int V_BINS = 180;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             detected;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   xmin;
    logic [X_W-1:0]   xmax;
    logic [Y_W-1:0]   ymin;
    logic [Y_W-1:0]   ymax;
  } result_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. Operands are
// captured on start; done pulses W cycles later with the floor quotient.
// A zero divisor yields an all-ones quotient, which callers must discard.
module seq_divider #(
  parameter int W = 25
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_reg;
  logic [W-1:0]  quo_reg;
  logic [W-1:0]  dvs_reg;
  logic [CW-1:0] cnt_reg;
  logic [W:0]    shifted;
  logic          fits;

  // Trial step: bring down the next dividend bit and test against the divisor
  always_comb begin
    shifted = {rem_reg, quo_reg[W-1]};
    fits    = (shifted >= {1'b0, dvs_reg});
  end

  // Load on start, then iterate W times; remainder restores when the trial fails
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_reg <= '0;
        quo_reg <= dividend;
        dvs_reg <= divisor;
        cnt_reg <= CW'(W);
        busy    <= 1'b1;
      end else if (busy) begin
        rem_reg <= fits ? W'(shifted - {1'b0, dvs_reg}) : W'(shifted);
        quo_reg <= {quo_reg[W-2:0], fits};
        cnt_reg <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_reg;

endmodule

// File: rtl/binned_centroid.sv
// Per-frame statistics of set pixels in the binned stream: count, bounding
// box and integer centroid. Accumulators snapshot at frame end and feed two
// sequential dividers, so the next frame accumulates while the divide runs.
module binned_centroid #(
  parameter int H_BINS    = 320,
  parameter int V_BINS    = 180,
  parameter int MIN_COUNT = 16,
  parameter int DIV_W     = 25
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [8:0]  hcount_in,
  input  logic [7:0]  vcount_in,
  input  logic        bit_in,
  input  logic        frame_end_in,
  output logic        valid_out,
  output logic        detected_out,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic [15:0] count_out,
  output logic [8:0]  xmin_out,
  output logic [8:0]  xmax_out,
  output logic [7:0]  ymin_out,
  output logic [7:0]  ymax_out,
  output logic        busy_out,
  output logic        overrun_out
);

  import binned_pkg::*;

  localparam int SX_W = 25;
  localparam int SY_W = 24;
  localparam logic [X_W-1:0]   H_LIM   = X_W'(H_BINS);
  localparam logic [Y_W-1:0]   V_LIM   = Y_W'(V_BINS);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg, count_next, count_shadow_reg;
  logic [SX_W-1:0]  sum_x_reg, sum_x_next;
  logic [SY_W-1:0]  sum_y_reg, sum_y_next;
  logic [X_W-1:0]   xmin_reg, xmin_next, xmin_shadow_reg;
  logic [X_W-1:0]   xmax_reg, xmax_next, xmax_shadow_reg;
  logic [Y_W-1:0]   ymin_reg, ymin_next, ymin_shadow_reg;
  logic [Y_W-1:0]   ymax_reg, ymax_next, ymax_shadow_reg;
  result_t          result_reg, result_next;
  logic             overrun_reg;
  logic             pix_ok, accept;
  logic             div_x_busy, div_y_busy, div_x_done, div_y_done;
  logic [DIV_W-1:0] quo_x, quo_y;
  logic             unused_quo_bits;

  // Accumulator values including this cycle's pixel, so a pixel coincident
  // with frame end lands in the snapshot of the ending frame
  always_comb begin
    pix_ok     = valid_in && bit_in && (hcount_in < H_LIM) && (vcount_in < V_LIM);
    accept     = frame_end_in && (state_reg == ACCUM);
    count_next = count_reg + CNT_W'(pix_ok);
    sum_x_next = sum_x_reg + (pix_ok ? SX_W'(hcount_in) : '0);
    sum_y_next = sum_y_reg + (pix_ok ? SY_W'(vcount_in) : '0);
    xmin_next  = (pix_ok && hcount_in < xmin_reg) ? hcount_in : xmin_reg;
    xmax_next  = (pix_ok && hcount_in > xmax_reg) ? hcount_in : xmax_reg;
    ymin_next  = (pix_ok && vcount_in < ymin_reg) ? vcount_in : ymin_reg;
    ymax_next  = (pix_ok && vcount_in > ymax_reg) ? vcount_in : ymax_reg;
  end

  // Running accumulators; every frame end clears them, accepted or dropped
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in || frame_end_in) begin
      count_reg <= '0;
      sum_x_reg <= '0;
      sum_y_reg <= '0;
      xmin_reg  <= '1;
      xmax_reg  <= '0;
      ymin_reg  <= '1;
      ymax_reg  <= '0;
    end else begin
      count_reg <= count_next;
      sum_x_reg <= sum_x_next;
      sum_y_reg <= sum_y_next;
      xmin_reg  <= xmin_next;
      xmax_reg  <= xmax_next;
      ymin_reg  <= ymin_next;
      ymax_reg  <= ymax_next;
    end
  end

  // Shadow copy of the frame being divided; the sums go straight to the dividers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_shadow_reg <= '0;
      xmin_shadow_reg  <= '0;
      xmax_shadow_reg  <= '0;
      ymin_shadow_reg  <= '0;
      ymax_shadow_reg  <= '0;
    end else if (accept) begin
      count_shadow_reg <= count_next;
      xmin_shadow_reg  <= xmin_next;
      xmax_shadow_reg  <= xmax_next;
      ymin_shadow_reg  <= ymin_next;
      ymax_shadow_reg  <= ymax_next;
    end
  end

  seq_divider #(.W(DIV_W)) u_div_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (accept),
    .dividend (DIV_W'(sum_x_next)),
    .divisor  (DIV_W'(count_next)),
    .busy     (div_x_busy),
    .done     (div_x_done),
    .quotient (quo_x)
  );

  seq_divider #(.W(DIV_W)) u_div_y (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (accept),
    .dividend (DIV_W'(sum_y_next)),
    .divisor  (DIV_W'(count_next)),
    .busy     (div_y_busy),
    .done     (div_y_done),
    .quotient (quo_y)
  );

  // Result shaping: suppress centroid below threshold, bbox when the frame is empty
  always_comb begin
    result_next       = '0;
    result_next.count = count_shadow_reg;
    if (count_shadow_reg != '0) begin
      result_next.xmin = xmin_shadow_reg;
      result_next.xmax = xmax_shadow_reg;
      result_next.ymin = ymin_shadow_reg;
      result_next.ymax = ymax_shadow_reg;
    end
    if (count_shadow_reg >= MIN_CNT) begin
      result_next.detected = 1'b1;
      result_next.x        = quo_x[X_W-1:0];
      result_next.y        = quo_y[Y_W-1:0];
    end
  end

  // Result path FSM; results latch on the edge that enters DONE
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg  <= ACCUM;
      result_reg <= '0;
    end else begin
      case (state_reg)
        ACCUM: if (accept) state_reg <= DIV;
        DIV: begin
          if (div_x_done && div_y_done) begin
            state_reg  <= DONE;
            result_reg <= result_next;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  // Sticky flag for frame ends that arrive while a result is still pending
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) overrun_reg <= 1'b0;
    else if (frame_end_in && state_reg != ACCUM) overrun_reg <= 1'b1;
  end

  assign unused_quo_bits = ^{quo_x[DIV_W-1:X_W], quo_y[DIV_W-1:Y_W]};

  assign valid_out    = (state_reg == DONE);
  assign busy_out     = (state_reg == DIV) || div_x_busy || div_y_busy;
  assign overrun_out  = overrun_reg;
  assign detected_out = result_reg.detected;
  assign x_out        = result_reg.x;
  assign y_out        = result_reg.y;
  assign count_out    = result_reg.count;
  assign xmin_out     = result_reg.xmin;
  assign xmax_out     = result_reg.xmax;
  assign ymin_out     = result_reg.ymin;
  assign ymax_out     = result_reg.ymax;

endmodule

// File: tb/tb_binned_centroid.sv
// Scoreboard bench for binned_centroid: the stimulus side keeps a pixel list
// per frame and queues the expected result at frame end; a negedge monitor
// pops and compares whenever valid_out appears.
module tb_binned_centroid;

  localparam int W    = 25;
  localparam int MINC = 16;
  localparam int HB   = 320;
  localparam int VB   = 180;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [8:0]  hcount_in = '0;
  logic [7:0]  vcount_in = '0;
  logic        bit_in = 1'b0;
  logic        frame_end_in = 1'b0;
  logic        valid_out, detected_out, busy_out, overrun_out;
  logic [8:0]  x_out, xmin_out, xmax_out;
  logic [7:0]  y_out, ymin_out, ymax_out;
  logic [15:0] count_out;

  binned_centroid #(.H_BINS(HB), .V_BINS(VB), .MIN_COUNT(MINC), .DIV_W(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .bit_in(bit_in),
    .frame_end_in(frame_end_in), .valid_out(valid_out),
    .detected_out(detected_out), .x_out(x_out), .y_out(y_out),
    .count_out(count_out), .xmin_out(xmin_out), .xmax_out(xmax_out),
    .ymin_out(ymin_out), .ymax_out(ymax_out), .busy_out(busy_out),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int count; bit det; int x; int y;
    int xmin; int xmax; int ymin; int ymax;
    int when;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   px[$];
  int   py[$];
  int   k_acc;
  bit   have_acc;
  int   ovr_cyc;
  int   errors = 0;
  int   checks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d at cycle %0d", name, act, act, exp, cyc);
    end
  endfunction

  function automatic void reset_model();
    q.delete();
    px.delete();
    py.delete();
    last     = '{default: 0};
    have_acc = 1'b0;
    k_acc    = 0;
    ovr_cyc  = 1 << 30;
  endfunction

  // Reference: statistics straight from the list of set pixels in the frame
  function automatic void model_frame_end();
    exp_t e;
    int sx, sy, n;
    if (have_acc && (cyc - k_acc) < W + 3) begin
      if (ovr_cyc > cyc + 1) ovr_cyc = cyc + 1;
    end else begin
      n  = px.size();
      sx = 0; sy = 0;
      e  = '{default: 0};
      e.xmin = 511; e.ymin = 255;
      foreach (px[i]) begin
        sx += px[i]; sy += py[i];
        if (px[i] < e.xmin) e.xmin = px[i];
        if (px[i] > e.xmax) e.xmax = px[i];
        if (py[i] < e.ymin) e.ymin = py[i];
        if (py[i] > e.ymax) e.ymax = py[i];
      end
      e.count = n;
      if (n == 0) begin
        e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
      end
      e.det = (n >= MINC);
      e.x   = e.det ? sx / n : 0;
      e.y   = e.det ? sy / n : 0;
      e.when = cyc + W + 2;
      q.push_back(e);
      k_acc    = cyc;
      have_acc = 1'b1;
    end
    px.delete();
    py.delete();
  endfunction

  task automatic step(input bit v, input int h, input int vv, input bit b, input bit fe);
    valid_in     = v;
    hcount_in    = 9'(h);
    vcount_in    = 8'(vv);
    bit_in       = b;
    frame_end_in = fe;
    if (v && b && h < HB && vv < VB) begin
      px.push_back(h);
      py.push_back(vv);
    end
    if (fe) model_frame_end();
    @(posedge clk_in);
    #1;
    valid_in     = 1'b0;
    bit_in       = 1'b0;
    frame_end_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic rand_pix();
    step($urandom_range(0, 9) < 8, $urandom_range(0, 330), $urandom_range(0, 190),
         $urandom_range(0, 1), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_overrun"}, overrun_out, 0);
    check({tag, "_det"}, detected_out, 0);
    check({tag, "_count"}, count_out, 0);
    check({tag, "_xy"}, {x_out, y_out}, 0);
    check({tag, "_bbox"}, {xmin_out, xmax_out, ymin_out, ymax_out}, 0);
  endtask

  // Monitor: compare on valid_out, otherwise outputs must hold the last result
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      if (valid_out === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_out=1 expected no result at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          check("latency", cyc, e.when);
          check("count", count_out, e.count);
          check("detected", detected_out, e.det);
          check("x", x_out, e.x);
          check("y", y_out, e.y);
          check("xmin", xmin_out, e.xmin);
          check("xmax", xmax_out, e.xmax);
          check("ymin", ymin_out, e.ymin);
          check("ymax", ymax_out, e.ymax);
          check("busy_at_valid", busy_out, 0);
          $display("result cyc=%0d count=%0d det=%0d x=%0d y=%0d bbox=(%0d,%0d,%0d,%0d)",
                   cyc, count_out, detected_out, x_out, y_out,
                   xmin_out, xmax_out, ymin_out, ymax_out);
          last = e;
        end
      end else begin
        check("hold_count", count_out, last.count);
        check("hold_xy", {x_out, y_out}, {9'(last.x), 8'(last.y)});
        check("hold_det", detected_out, last.det);
      end
      check("overrun", overrun_out, cyc >= ovr_cyc);
    end
  end

  initial begin
    reset_model();
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset");
    rst_in = 1'b0;
    idle(2);

    // Single pixel: below threshold, bbox still reported
    step(1, 10, 20, 1, 0);
    step(0, 0, 0, 0, 1);
    check("busy_after_fe", busy_out, 1);
    idle(35);

    // 4x4 block: exact threshold, floor centroid
    for (int r = 50; r < 54; r++)
      for (int c = 100; c < 104; c++)
        step(1, c, r, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(35);

    // Empty frame
    step(0, 0, 0, 0, 1);
    idle(35);

    // Overrun: second frame end 10 cycles after the first is dropped
    for (int i = 0; i < 20; i++) step(1, 30 + i, 40, 1, 0);
    step(0, 0, 0, 0, 1);
    step(1, 60, 60, 1, 0);
    idle(8);
    step(1, 61, 61, 1, 1);
    idle(35);
    check("overrun_sticky", overrun_out, 1);
    for (int i = 0; i < 17; i++) step(1, 250, 170 + (i % 10), 1, 0);
    step(0, 0, 0, 0, 1);
    idle(35);

    // Coincident pixel counts; out-of-range coordinates ignored
    for (int i = 0; i < 15; i++) step(1, 190 + i, 90, 1, 0);
    step(1, 320, 3, 1, 0);
    step(1, 5, 180, 1, 0);
    step(1, 200, 100, 1, 1);
    idle(35);

    // Reset mid-division aborts the pending result
    for (int i = 0; i < 20; i++) step(1, i, i, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(12);
    rst_in = 1'b1;
    #1;
    check_zero("reset_mid_div");
    reset_model();
    idle(3);
    rst_in = 1'b0;
    idle(2);
    for (int i = 0; i < 18; i++) step(1, 300 - i, 10 + i, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(35);

    // Random frames with traffic overlapping the division
    for (int f = 0; f < 10; f++) begin
      int n;
      n = (f % 3 == 0) ? $urandom_range(0, 25) : $urandom_range(20, 150);
      for (int i = 0; i < n; i++) rand_pix();
      step($urandom_range(0, 1), $urandom_range(0, 330), $urandom_range(0, 190), 1, 1);
      n = $urandom_range(32, 40);
      for (int i = 0; i < n; i++) rand_pix();
    end

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk_in);
    #1;
    check("queue_drained", q.size(), 0);
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
